// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM Port B arbiter.
//   req_id_e : requester identity (REQ_PS = AXI-Lite bridge, REQ_PL = acquisition engine)
//   rd_tag_t : read-return tag {valid, id} carried alongside the BRAM read latency
//   BRAM_DATA_WIDTH / BRAM_BE_WIDTH : default data width and its byte-enable width
package bram_arb_pkg;

    localparam int unsigned BRAM_DATA_WIDTH = 32;
    localparam int unsigned BRAM_BE_WIDTH   = BRAM_DATA_WIDTH / 8;

    typedef enum logic {
        REQ_PS = 1'b0,
        REQ_PL = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Fixed-depth shift register of read tags. A tag entering on an accept leaves DEPTH cycles
// later, lined up with the BRAM read data it describes.
//   clk, rst : clock, asynchronous active-high reset (clears all in-flight tags)
//   tag_in   : tag captured every cycle (invalid tag when nothing to track)
//   tag_out  : oldest tag in the pipe
module bram_rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] pipe_q;

    // Index 0 holds the newest tag; DEPTH is always at least 2 (1 + read latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], tag_in};
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between requester 0 (PS bridge) and
// requester 1 (PL engine), with a bounded grant lock for requester 1 bursts.
//   rq_valid/rq_ready/rq_we/rq_addr/rq_wdata : per-requester access handshake and fields
//   rq_lock      : requester 1 asks to keep the grant across consecutive accesses
//   rs_valid     : per-requester read-data strobe; rs_rdata shared read data
//   bram_*       : registered BRAM Port B drive; bram_dout is the BRAM read data
//   lock_timeout : one-cycle pulse when a held lock is broken in favour of requester 0
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = BRAM_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_LOCK     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   rq_valid,
    output logic [1:0]                   rq_ready,
    input  logic [1:0][DATA_WIDTH/8-1:0] rq_we,
    input  logic [1:0][ADDR_WIDTH-1:0]   rq_addr,
    input  logic [1:0][DATA_WIDTH-1:0]   rq_wdata,
    input  logic                         rq_lock,
    output logic [1:0]                   rs_valid,
    output logic [DATA_WIDTH-1:0]        rs_rdata,
    output logic                         bram_clk,
    output logic                         bram_rst,
    output logic                         bram_en,
    output logic [DATA_WIDTH/8-1:0]      bram_we,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    output logic [DATA_WIDTH-1:0]        bram_din,
    input  logic [DATA_WIDTH-1:0]        bram_dout,
    output logic                         lock_timeout
);

    localparam int unsigned              BE_W       = DATA_WIDTH / 8;
    localparam int unsigned              CNT_W      = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]         LOCK_LIMIT = CNT_W'(MAX_LOCK);
    localparam logic [ADDR_WIDTH-1:0]    WORD_MASK  = ~ADDR_WIDTH'(3);

    req_id_e                 last_q, last_d;
    logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                    lock_hold;
    logic                    lock_expired;
    logic [1:0]              accept;
    logic                    any_accept;
    logic                    gnt_sel;

    logic                    bram_en_q;
    logic [BE_W-1:0]         bram_we_q;
    logic [ADDR_WIDTH-1:0]   bram_addr_q;
    logic [DATA_WIDTH-1:0]   bram_din_q;

    rd_tag_t                 tag_in, tag_out;

    // Grant: an expired lock forces requester 0; otherwise a tie goes to the lock holder or
    // to whoever was not granted last. A lone requester is simply granted.
    always_comb begin
        rq_ready     = 2'b00;
        lock_expired = (lock_cnt_q == LOCK_LIMIT);
        lock_hold    = rq_lock && (last_q == REQ_PL);
        if (!rst) begin
            if (lock_expired && rq_valid[0]) begin
                rq_ready = 2'b01;
            end else if (rq_valid == 2'b11) begin
                rq_ready = (lock_hold || (last_q == REQ_PS)) ? 2'b10 : 2'b01;
            end else begin
                rq_ready = rq_valid;
            end
        end
    end

    assign accept       = rq_valid & rq_ready;
    assign any_accept   = |accept;
    assign gnt_sel      = accept[1];
    assign lock_timeout = lock_expired && accept[0];

    always_comb begin
        last_d = last_q;
        if (any_accept) begin
            last_d = req_id_e'(gnt_sel);
        end

        // Only requester-1 grants that actually make requester 0 wait count against the lock.
        lock_cnt_d = lock_cnt_q;
        if (!rq_lock || accept[0]) begin
            lock_cnt_d = '0;
        end else if (accept[1] && rq_valid[0]) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end

        tag_in = '{valid: 1'b0, id: REQ_PS};
        if (any_accept && (rq_we[gnt_sel] == '0)) begin
            tag_in = '{valid: 1'b1, id: req_id_e'(gnt_sel)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= REQ_PL;
            lock_cnt_q  <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            bram_en_q  <= any_accept;
            if (any_accept) begin
                bram_we_q   <= rq_we[gnt_sel];
                bram_addr_q <= rq_addr[gnt_sel] & WORD_MASK;
                bram_din_q  <= rq_wdata[gnt_sel];
            end else begin
                bram_we_q <= '0;
            end
        end
    end

    bram_rd_tag_pipe #(
        .DEPTH (1 + READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign rs_valid[0] = tag_out.valid && (tag_out.id == REQ_PS);
    assign rs_valid[1] = tag_out.valid && (tag_out.id == REQ_PL);
    assign rs_rdata    = bram_dout;

    assign bram_clk  = clk;
    assign bram_rst  = rst;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    localparam int unsigned RL = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       rq_valid = '0;
    logic [1:0]       rq_ready;
    logic [1:0][3:0]  rq_we = '0;
    logic [1:0][15:0] rq_addr = '0;
    logic [1:0][31:0] rq_wdata = '0;
    logic             rq_lock = 1'b0;
    logic [1:0]       rs_valid;
    logic [31:0]      rs_rdata;
    logic             bram_clk, bram_rst, bram_en;
    logic [3:0]       bram_we;
    logic [15:0]      bram_addr;
    logic [31:0]      bram_din;
    logic [31:0]      bram_dout;
    logic             lock_timeout;

    bram_port_arbiter #(
        .ADDR_WIDTH   (16),
        .DATA_WIDTH   (32),
        .READ_LATENCY (RL),
        .MAX_LOCK     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rq_valid     (rq_valid),
        .rq_ready     (rq_ready),
        .rq_we        (rq_we),
        .rq_addr      (rq_addr),
        .rq_wdata     (rq_wdata),
        .rq_lock      (rq_lock),
        .rs_valid     (rs_valid),
        .rs_rdata     (rs_rdata),
        .bram_clk     (bram_clk),
        .bram_rst     (bram_rst),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        return 32'hA5000000 ^ (idx * 32'h00010203);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Write-first BRAM model with RL cycles of read latency.
    logic [31:0] mem [16384];
    bit          mem_seen [16384];
    logic [31:0] rdp [RL];
    always @(posedge clk) begin
        if (bram_en) begin
            mem[bram_addr[15:2]]      <= merge(mem_seen[bram_addr[15:2]] ? mem[bram_addr[15:2]]
                                               : init_word(int'(bram_addr[15:2])), bram_din, bram_we);
            mem_seen[bram_addr[15:2]] <= 1'b1;
            rdp[0]                    <= merge(mem_seen[bram_addr[15:2]] ? mem[bram_addr[15:2]]
                                               : init_word(int'(bram_addr[15:2])), bram_din, bram_we);
        end
        for (int k = 1; k < RL; k++) rdp[k] <= rdp[k-1];
    end
    assign bram_dout = rdp[RL-1];

    // Scoreboard of expected read returns.
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    logic [31:0] shadow [int];
    function automatic logic [31:0] shadow_rd(input int idx);
        return shadow.exists(idx) ? shadow[idx] : init_word(idx);
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            if (rs_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rs_unexpected", {62'd0, rs_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rs_valid_id", {62'd0, rs_valid}, e.id ? 64'd2 : 64'd1);
                    check("rs_rdata", {32'd0, rs_rdata}, {32'd0, e.data});
                    check("rs_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rs_missing", {62'd0, rs_valid}, e.id ? 64'd2 : 64'd1);
            end
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic        lock;
        logic [3:0]  we0;
        logic [15:0] a0;
        logic [31:0] d0;
        logic [3:0]  we1;
        logic [15:0] a1;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        to;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [1:0] v, input logic lock, input logic [3:0] we0,
                                input logic [15:0] a0, input logic [31:0] d0,
                                input logic [3:0] we1, input logic [15:0] a1,
                                input logic [31:0] d1, input logic [1:0] rdy, input logic to);
        vec_t t = '{v, lock, we0, a0, d0, we1, a1, d1, rdy, to};
        vecs.push_back(t);
    endfunction

    logic        exp_valid = 1'b0;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [15:0] hold_addr = '0;
    logic [31:0] hold_din = '0;

    // Entered just after a rising edge; returns just after the next one.
    task automatic step(input vec_t t);
        logic [3:0]  we;
        logic [15:0] a;
        logic [31:0] d;
        rsp_t        e;
        rq_valid    = t.v;
        rq_lock     = t.lock;
        rq_we[0]    = t.we0;
        rq_addr[0]  = t.a0;
        rq_wdata[0] = t.d0;
        rq_we[1]    = t.we1;
        rq_addr[1]  = t.a1;
        rq_wdata[1] = t.d1;
        @(negedge clk);
        if (exp_valid) begin
            check("bram_en", 64'(bram_en), 64'(exp_en));
            check("bram_we", 64'(bram_we), 64'(exp_we));
            check("bram_addr", 64'(bram_addr), 64'(hold_addr));
            check("bram_din", 64'(bram_din), 64'(hold_din));
        end
        check("rq_ready", 64'(rq_ready), 64'(t.rdy));
        check("lock_timeout", 64'(lock_timeout), 64'(t.to));
        exp_en = 1'b0;
        exp_we = '0;
        for (int r = 0; r < 2; r++) begin
            if (t.rdy[r]) begin
                we = r ? t.we1 : t.we0;
                a  = r ? t.a1 : t.a0;
                d  = r ? t.d1 : t.d0;
                exp_en    = 1'b1;
                exp_we    = we;
                hold_addr = a & 16'hFFFC;
                hold_din  = d;
                if (we == 4'd0) begin
                    e.id   = (r == 1);
                    e.data = shadow_rd(int'(a[15:2]));
                    e.due  = cyc + 1 + RL;
                    sb.push_back(e);
                end else begin
                    shadow[int'(a[15:2])] = merge(shadow_rd(int'(a[15:2])), d, we);
                end
            end
        end
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vec_t t = '{2'b00, 1'b0, 4'd0, 16'd0, 32'd0, 4'd0, 16'd0, 32'd0, 2'b00, 1'b0};
        for (int i = 0; i < n; i++) step(t);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rq_ready"}, 64'(rq_ready), 64'd0);
        check({tag, "_rs_valid"}, 64'(rs_valid), 64'd0);
        check({tag, "_bram_en"}, 64'(bram_en), 64'd0);
        check({tag, "_bram_we"}, 64'(bram_we), 64'd0);
        check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
        check({tag, "_bram_din"}, 64'(bram_din), 64'd0);
        check({tag, "_lock_timeout"}, 64'(lock_timeout), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        // Contention: alternating reads, requester 0 first after reset.
        add(2'b11, 0, 0, 16'h0020, 0, 0, 16'h0040, 0, 2'b01, 0);
        add(2'b11, 0, 0, 16'h0024, 0, 0, 16'h0040, 0, 2'b10, 0);
        add(2'b11, 0, 0, 16'h0024, 0, 0, 16'h0044, 0, 2'b01, 0);
        add(2'b11, 0, 0, 16'h0028, 0, 0, 16'h0044, 0, 2'b10, 0);
        add(2'b11, 0, 0, 16'h0028, 0, 0, 16'h0048, 0, 2'b01, 0);
        add(2'b11, 0, 0, 16'h002C, 0, 0, 16'h0048, 0, 2'b10, 0);
        add(2'b11, 0, 0, 16'h002C, 0, 0, 16'h004C, 0, 2'b01, 0);
        add(2'b11, 0, 0, 16'h0030, 0, 0, 16'h004C, 0, 2'b10, 0);
        // Single writer then reader; unaligned partial write; read-after-write by requester 1.
        add(2'b01, 0, 4'hF, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 2'b01, 0);
        add(2'b01, 0, 4'h0, 16'h0010, 0, 0, 0, 0, 2'b01, 0);
        add(2'b01, 0, 4'h3, 16'h0013, 32'h12345678, 0, 0, 0, 2'b01, 0);
        add(2'b10, 0, 0, 0, 0, 0, 16'h0012, 0, 2'b10, 0);
        add(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // Lock with MAX_LOCK=4: four waiting grants to requester 1, forced requester 0, then 1.
        add(2'b10, 1, 0, 0, 0, 0, 16'h0080, 0, 2'b10, 0);
        add(2'b11, 1, 0, 16'h0030, 0, 0, 16'h0084, 0, 2'b10, 0);
        add(2'b11, 1, 0, 16'h0030, 0, 0, 16'h0088, 0, 2'b10, 0);
        add(2'b11, 1, 0, 16'h0030, 0, 0, 16'h008C, 0, 2'b10, 0);
        add(2'b11, 1, 0, 16'h0030, 0, 0, 16'h0090, 0, 2'b10, 0);
        add(2'b11, 1, 0, 16'h0030, 0, 0, 16'h0094, 0, 2'b01, 1);
        add(2'b11, 1, 0, 16'h0034, 0, 0, 16'h0094, 0, 2'b10, 0);
        add(2'b11, 1, 0, 16'h0034, 0, 0, 16'h0098, 0, 2'b10, 0);
        add(2'b11, 0, 0, 16'h0034, 0, 0, 16'h009C, 0, 2'b01, 0);
        add(2'b10, 0, 0, 0, 0, 0, 16'h009C, 0, 2'b10, 0);
        add(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

        // Reset held three cycles with both requesters presenting reads.
        rst         = 1'b1;
        rq_valid    = 2'b11;
        rq_addr[0]  = 16'h0020;
        rq_addr[1]  = 16'h0040;
        repeat (3) begin
            @(negedge clk);
            reset_checks("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Two reads in flight, then reset: neither may return.
        t = '{2'b01, 1'b0, 4'd0, 16'h0010, 32'd0, 4'd0, 16'd0, 32'd0, 2'b01, 1'b0};
        step(t);
        t = '{2'b10, 1'b0, 4'd0, 16'd0, 32'd0, 4'd0, 16'h0024, 32'd0, 2'b10, 1'b0};
        step(t);
        rst       = 1'b1;
        rq_valid  = 2'b00;
        sb.delete();
        exp_valid = 1'b0;
        hold_addr = '0;
        hold_din  = '0;
        repeat (2) begin
            @(negedge clk);
            reset_checks("midrst");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(RL + 2);
        t = '{2'b01, 1'b0, 4'd0, 16'h0011, 32'd0, 4'd0, 16'd0, 32'd0, 2'b01, 1'b0};
        step(t);
        idle(RL + 3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
